// File: rtl/fixed_encoder_var_order_pkg.sv
// Shared constants, coefficient tables and types for the runtime-order fixed FLAC predictor.
package flac_fixed_pkg;

   localparam int MAX_FIXED_ORDER = 4;
   localparam int ORDER_W         = 3;

   typedef logic [ORDER_W-1:0] order_t;
   typedef logic [2:0]         coef_t;

   // Binomial magnitudes; signs alternate and are applied by the p/q split in the datapath.
   localparam coef_t K1_TAB [MAX_FIXED_ORDER+1] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
   localparam coef_t K2_TAB [MAX_FIXED_ORDER+1] = '{3'd0, 3'd0, 3'd1, 3'd3, 3'd6};
   localparam coef_t K3_TAB [MAX_FIXED_ORDER+1] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd4};
   localparam coef_t K4_TAB [MAX_FIXED_ORDER+1] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd1};

   typedef struct packed {
      logic   isStart;
      logic   isLast;
      logic   isWarmup;
      order_t order;
   } tag_t;

   function automatic order_t clampOrder(input order_t ord);
      return (ord > order_t'(MAX_FIXED_ORDER)) ? order_t'(MAX_FIXED_ORDER) : ord;
   endfunction

endpackage

// File: rtl/fixed_encoder_var_order_if.sv
// Sample-in / residual-out bundle of the fixed encoder; the slave side is the encoder.
interface fixed_encoder_var_order_if #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SUM_WIDTH    = 32
);
   import flac_fixed_pkg::*;

   localparam int RES_WIDTH = SAMPLE_WIDTH + 4;

   logic                           iEnable;
   logic                           iFrameStart;
   logic                           iFrameLast;
   order_t                         iOrder;
   logic signed [SAMPLE_WIDTH-1:0] iSample;

   logic                           oValid;
   logic                           oWarmup;
   logic signed [RES_WIDTH-1:0]    oResidual;
   order_t                         oOrder;
   logic [SUM_WIDTH-1:0]           oAbsSum;
   logic                           oSumValid;

   modport master (
      output iEnable, iFrameStart, iFrameLast, iOrder, iSample,
      input  oValid, oWarmup, oResidual, oOrder, oAbsSum, oSumValid
   );

   modport slave (
      input  iEnable, iFrameStart, iFrameLast, iOrder, iSample,
      output oValid, oWarmup, oResidual, oOrder, oAbsSum, oSumValid
   );
endinterface

// File: rtl/fixed_encoder_var_order_accumulator.sv
// Per-frame sum of |residual| with saturation; publishes the total one cycle after the last sample.
module fixed_abs_accumulator #(
   parameter int RES_WIDTH = 20,
   parameter int SUM_WIDTH = 32
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        valid_i,
   input  logic                        start_i,
   input  logic                        last_i,
   input  logic                        warmup_i,
   input  logic signed [RES_WIDTH-1:0] residual_i,
   output logic [SUM_WIDTH-1:0]        absSum_o,
   output logic                        sumValid_o
);

   logic [SUM_WIDTH-1:0] acc_q, acc_d;
   logic [SUM_WIDTH-1:0] absSum_q;
   logic                 sumValid_q;
   logic [RES_WIDTH-1:0] magRes;
   logic [SUM_WIDTH-1:0] magExt;
   logic [SUM_WIDTH:0]   sumWide;

   // The most negative residual is unreachable, so a plain negate is a safe magnitude.
   always_comb begin
      magRes  = residual_i[RES_WIDTH-1] ? -residual_i : residual_i;
      magExt  = warmup_i ? '0 : SUM_WIDTH'(magRes);
      sumWide = {1'b0, acc_q} + {1'b0, magExt};
      acc_d   = acc_q;
      if (start_i) begin
         acc_d = magExt;
      end else if (sumWide[SUM_WIDTH]) begin
         acc_d = '1;
      end else begin
         acc_d = sumWide[SUM_WIDTH-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q      <= '0;
         absSum_q   <= '0;
         sumValid_q <= 1'b0;
      end else begin
         sumValid_q <= valid_i & last_i;
         if (valid_i) begin
            acc_q <= acc_d;
            if (last_i) begin
               absSum_q <= acc_d;
            end
         end
      end
   end

   assign absSum_o   = absSum_q;
   assign sumValid_o = sumValid_q;

endmodule

// File: rtl/fixed_encoder_var_order.sv
// Fixed FLAC predictor of runtime order 0..4: three-stage residual pipeline plus per-frame |residual| sum.
module fixed_encoder_var_order
   import flac_fixed_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 16,
   parameter int SUM_WIDTH    = 32
) (
   input  logic                     iClock,
   input  logic                     iReset_n,
   fixed_encoder_var_order_if.slave bus
);

   localparam int RES_WIDTH = SAMPLE_WIDTH + 4;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;
   typedef logic signed [RES_WIDTH-1:0]    res_t;

   function automatic res_t widen(input sample_t x);
      return res_t'(x);
   endfunction

   function automatic res_t scale(input res_t x, input coef_t k);
      res_t r;
      case (k)
         3'd1:    r = x;
         3'd2:    r = x <<< 1;
         3'd3:    r = (x <<< 1) + x;
         3'd4:    r = x <<< 2;
         3'd6:    r = (x <<< 2) + (x <<< 1);
         default: r = '0;
      endcase
      return r;
   endfunction

   order_t  frameOrder_q, frameOrder_d;
   order_t  count_q, count_d, curCount;
   sample_t x0_q, x1_q, x2_q, x3_q, x4_q;
   logic    s0Valid_q;
   tag_t    s0Tag_q, s0Tag_d;

   res_t    p_q, p_d, q_q, q_d;
   sample_t s1Sample_q;
   logic    s1Valid_q;
   tag_t    s1Tag_q;

   res_t    residual_q, residual_d;
   logic    s2Valid_q, s2Warmup_q, s2Start_q, s2Last_q;
   order_t  s2Order_q;

   // A frame start overrides the running order/counter for the very sample that carries it.
   always_comb begin
      frameOrder_d     = bus.iFrameStart ? clampOrder(bus.iOrder) : frameOrder_q;
      curCount         = bus.iFrameStart ? '0 : count_q;
      count_d          = (curCount >= order_t'(MAX_FIXED_ORDER)) ? order_t'(MAX_FIXED_ORDER)
                                                                 : curCount + 3'd1;
      s0Tag_d.isStart  = bus.iFrameStart;
      s0Tag_d.isLast   = bus.iFrameLast;
      s0Tag_d.isWarmup = curCount < frameOrder_d;
      s0Tag_d.order    = frameOrder_d;
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         s0Valid_q    <= 1'b0;
         frameOrder_q <= '0;
         count_q      <= '0;
         s0Tag_q      <= '0;
         x0_q         <= '0;
         x1_q         <= '0;
         x2_q         <= '0;
         x3_q         <= '0;
         x4_q         <= '0;
      end else begin
         s0Valid_q <= bus.iEnable;
         if (bus.iEnable) begin
            x0_q         <= bus.iSample;
            x1_q         <= x0_q;
            x2_q         <= x1_q;
            x3_q         <= x2_q;
            x4_q         <= x3_q;
            frameOrder_q <= frameOrder_d;
            count_q      <= count_d;
            s0Tag_q      <= s0Tag_d;
         end
      end
   end

   // Even-lag taps feed p and odd-lag taps feed q, so the residual is simply p - q.
   always_comb begin
      p_d = widen(x0_q)
          + scale(widen(x2_q), K2_TAB[s0Tag_q.order])
          + scale(widen(x4_q), K4_TAB[s0Tag_q.order]);
      q_d = scale(widen(x1_q), K1_TAB[s0Tag_q.order])
          + scale(widen(x3_q), K3_TAB[s0Tag_q.order]);
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         s1Valid_q  <= 1'b0;
         p_q        <= '0;
         q_q        <= '0;
         s1Sample_q <= '0;
         s1Tag_q    <= '0;
      end else begin
         s1Valid_q <= s0Valid_q;
         if (s0Valid_q) begin
            p_q        <= p_d;
            q_q        <= q_d;
            s1Sample_q <= x0_q;
            s1Tag_q    <= s0Tag_q;
         end
      end
   end

   always_comb begin
      residual_d = s1Tag_q.isWarmup ? widen(s1Sample_q) : p_q - q_q;
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         s2Valid_q  <= 1'b0;
         s2Warmup_q <= 1'b0;
         s2Start_q  <= 1'b0;
         s2Last_q   <= 1'b0;
         s2Order_q  <= '0;
         residual_q <= '0;
      end else begin
         s2Valid_q <= s1Valid_q;
         if (s1Valid_q) begin
            residual_q <= residual_d;
            s2Warmup_q <= s1Tag_q.isWarmup;
            s2Start_q  <= s1Tag_q.isStart;
            s2Last_q   <= s1Tag_q.isLast;
            s2Order_q  <= s1Tag_q.order;
         end
      end
   end

   assign bus.oValid    = s2Valid_q;
   assign bus.oWarmup   = s2Warmup_q;
   assign bus.oResidual = residual_q;
   assign bus.oOrder    = s2Order_q;

   fixed_abs_accumulator #(
      .RES_WIDTH (RES_WIDTH),
      .SUM_WIDTH (SUM_WIDTH)
   ) uAccumulator (
      .clk_i      (iClock),
      .rst_ni     (iReset_n),
      .valid_i    (s2Valid_q),
      .start_i    (s2Start_q),
      .last_i     (s2Last_q),
      .warmup_i   (s2Warmup_q),
      .residual_i (residual_q),
      .absSum_o   (bus.oAbsSum),
      .sumValid_o (bus.oSumValid)
   );

endmodule

// File: tb/tb_fixed_encoder_var_order.sv
// Directed bench for fixed_encoder_var_order: binomial-difference model per frame, checked every cycle.
module tb_fixed_encoder_var_order;
   import flac_fixed_pkg::*;

   localparam int     SW      = 16;
   localparam int     SUMW    = 32;
   localparam int     DEPTH   = 1024;
   localparam longint SUM_MAX = (longint'(1) <<< SUMW) - 1;

   logic iClock   = 1'b0;
   logic iReset_n = 1'b1;

   always #5 iClock = ~iClock;

   fixed_encoder_var_order_if #(.SAMPLE_WIDTH(SW), .SUM_WIDTH(SUMW)) bus ();

   fixed_encoder_var_order #(.SAMPLE_WIDTH(SW), .SUM_WIDTH(SUMW)) dut (
      .iClock   (iClock),
      .iReset_n (iReset_n),
      .bus      (bus)
   );

   int cyc = 0;
   always @(posedge iClock) cyc <= cyc + 1;

   // Expected per-cycle output stream, filled when each sample is driven.
   bit     expValid    [DEPTH];
   bit     expWarm     [DEPTH];
   longint expRes      [DEPTH];
   int     expOrd      [DEPTH];
   bit     expSumValid [DEPTH];
   longint expSumVal   [DEPTH];
   bit     pinResSet   [DEPTH];
   longint pinResVal   [DEPTH];
   bit     pinSumSet   [DEPTH];
   longint pinSumVal   [DEPTH];
   bit     pinOrdSet   [DEPTH];
   int     pinOrdVal   [DEPTH];

   int     mOrder = 0;
   int     mIdx   = 0;
   longint mSum   = 0;
   longint frameQ [$];
   int     lastDrive = 0;
   bit     running   = 1'b0;

   int     nVectors     = 0;
   int     nMiscompares = 0;
   longint heldAbs      = 0;

   function automatic int binom(input int n, input int k);
      int r = 1;
      for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
      return r;
   endfunction

   task automatic checkOutput(input string name, input longint actual, input longint expected);
      nVectors++;
      if (actual !== expected) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input bit en, input bit start, input bit last,
                                input int order, input longint sample);
      longint r;
      longint absv;
      bit     warm;
      int     k;
      @(posedge iClock);
      #1;
      bus.iEnable     = en;
      bus.iFrameStart = en & start;
      bus.iFrameLast  = en & last;
      bus.iOrder      = 3'(order);
      bus.iSample     = SW'(sample);
      lastDrive       = cyc;
      if (en) begin
         if (start) begin
            mOrder = (order > 4) ? 4 : order;
            mIdx   = 0;
            mSum   = 0;
            frameQ.delete();
         end
         frameQ.push_back(sample);
         warm = mIdx < mOrder;
         r    = 0;
         if (warm) begin
            r = sample;
         end else begin
            for (int j = 0; j <= mOrder; j++) begin
               k = binom(mOrder, j);
               r += longint'(((j % 2) == 1) ? -k : k) * frameQ[frameQ.size() - 1 - j];
            end
         end
         absv = warm ? 0 : ((r < 0) ? -r : r);
         mSum = mSum + absv;
         if (mSum > SUM_MAX) mSum = SUM_MAX;
         mIdx++;
         expValid[cyc+3] = 1'b1;
         expWarm[cyc+3]  = warm;
         expRes[cyc+3]   = r;
         expOrd[cyc+3]   = mOrder;
         if (last) begin
            expSumValid[cyc+4] = 1'b1;
            expSumVal[cyc+4]   = mSum;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 1'b0, 1'b0, 0, 0);
   endtask

   task automatic pinResidual(input longint v);
      pinResSet[lastDrive+3] = 1'b1;
      pinResVal[lastDrive+3] = v;
   endtask

   task automatic pinSum(input longint v);
      pinSumSet[lastDrive+4] = 1'b1;
      pinSumVal[lastDrive+4] = v;
   endtask

   task automatic pinOrder(input int v);
      pinOrdSet[lastDrive+3] = 1'b1;
      pinOrdVal[lastDrive+3] = v;
   endtask

   // Everything already in flight is dropped by reset, so forget all expectations from now on.
   task automatic doReset(input int holdCycles);
      @(posedge iClock);
      #1;
      iReset_n        = 1'b0;
      bus.iEnable     = 1'b0;
      bus.iFrameStart = 1'b0;
      bus.iFrameLast  = 1'b0;
      for (int i = cyc; i < DEPTH; i++) begin
         expValid[i]    = 1'b0;
         expSumValid[i] = 1'b0;
         pinResSet[i]   = 1'b0;
         pinSumSet[i]   = 1'b0;
         pinOrdSet[i]   = 1'b0;
      end
      mOrder = 0;
      mIdx   = 0;
      mSum   = 0;
      frameQ.delete();
      repeat (holdCycles) @(posedge iClock);
      #1;
      iReset_n = 1'b1;
   endtask

   always @(negedge iClock) begin
      if (running && cyc < DEPTH) begin
         if (!iReset_n) begin
            heldAbs = 0;
            checkOutput("rst_oValid",    longint'(bus.oValid),    0);
            checkOutput("rst_oWarmup",   longint'(bus.oWarmup),   0);
            checkOutput("rst_oResidual", longint'(bus.oResidual), 0);
            checkOutput("rst_oOrder",    longint'(bus.oOrder),    0);
            checkOutput("rst_oAbsSum",   longint'(bus.oAbsSum),   0);
            checkOutput("rst_oSumValid", longint'(bus.oSumValid), 0);
         end else begin
            checkOutput("oValid", longint'(bus.oValid), longint'(expValid[cyc]));
            if (expValid[cyc]) begin
               checkOutput("oWarmup",   longint'(bus.oWarmup),   longint'(expWarm[cyc]));
               checkOutput("oResidual", longint'(bus.oResidual), expRes[cyc]);
               checkOutput("oOrder",    longint'(bus.oOrder),    longint'(expOrd[cyc]));
            end
            checkOutput("oSumValid", longint'(bus.oSumValid), longint'(expSumValid[cyc]));
            if (expSumValid[cyc]) heldAbs = expSumVal[cyc];
            checkOutput("oAbsSum", longint'(bus.oAbsSum), heldAbs);
            if (pinResSet[cyc]) checkOutput("pin_residual", longint'(bus.oResidual), pinResVal[cyc]);
            if (pinSumSet[cyc]) checkOutput("pin_abssum",   longint'(bus.oAbsSum),   pinSumVal[cyc]);
            if (pinOrdSet[cyc]) checkOutput("pin_order",    longint'(bus.oOrder),    longint'(pinOrdVal[cyc]));
         end
      end
   end

   initial begin
      longint s;
      bus.iEnable     = 1'b0;
      bus.iFrameStart = 1'b0;
      bus.iFrameLast  = 1'b0;
      bus.iOrder      = '0;
      bus.iSample     = '0;
      running         = 1'b1;
      #2 iReset_n     = 1'b0;
      repeat (3) @(posedge iClock);
      #1 iReset_n     = 1'b1;

      // Order 0 passthrough.
      applyStimulus(1, 1, 0, 0, 5);  pinResidual(5);
      applyStimulus(1, 0, 0, 0, -3); pinResidual(-3);
      applyStimulus(1, 0, 1, 0, 7);  pinResidual(7); pinSum(15);
      idle(5);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, i == 0, i == 9, 3, i);
         pinResidual((i < 3) ? i : 0);
      end
      pinSum(0);
      idle(3);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, i == 0, i == 9, 1, i);
         pinResidual((i < 1) ? 0 : 1);
      end
      pinSum(9);
      idle(3);

      // Full-scale alternation at order 4 must not wrap.
      for (int i = 0; i < 5; i++) begin
         s = ((i % 2) == 0) ? -32768 : 32767;
         applyStimulus(1, i == 0, i == 4, 4, s);
      end
      pinResidual(-524280); pinSum(524280);
      idle(3);

      // Back-to-back frames; the second requests order 6.
      applyStimulus(1, 1, 0, 1, 10); pinResidual(10);
      applyStimulus(1, 0, 0, 1, 13); pinResidual(3);
      applyStimulus(1, 0, 0, 1, 7);  pinResidual(-6);
      applyStimulus(1, 0, 1, 1, 7);  pinResidual(0); pinSum(9);
      applyStimulus(1, 1, 0, 6, 3);  pinOrder(4);
      applyStimulus(1, 0, 0, 6, 1);
      applyStimulus(1, 0, 0, 6, 4);
      applyStimulus(1, 0, 0, 6, 1);
      applyStimulus(1, 0, 1, 6, 5);  pinResidual(24); pinSum(24);
      idle(3);

      // Gapped frame cut short by reset.
      applyStimulus(1, 1, 0, 2, 100);
      idle(1);
      applyStimulus(1, 0, 0, 2, 50);
      idle(1);
      applyStimulus(1, 0, 0, 2, 70);
      doReset(2);

      applyStimulus(1, 1, 0, 2, 1);  pinResidual(1);
      applyStimulus(1, 0, 0, 2, 4);  pinResidual(4);
      applyStimulus(1, 0, 0, 2, 9);  pinResidual(2);
      applyStimulus(1, 0, 1, 2, 16); pinResidual(2); pinSum(4);
      idle(2);

      applyStimulus(1, 1, 1, 2, -77); pinResidual(-77); pinSum(0);
      idle(3);

      // Abandoned frame: only the second frame reports a sum.
      applyStimulus(1, 1, 0, 0, 5);
      applyStimulus(1, 0, 0, 0, 6);
      applyStimulus(1, 1, 0, 0, 2);
      applyStimulus(1, 0, 1, 0, 3);  pinSum(5);
      idle(3);

      // Samples without a frame start after reset run at order 0; iOrder is ignored.
      doReset(2);
      applyStimulus(1, 0, 0, 5, 4);  pinOrder(0);
      applyStimulus(1, 0, 1, 0, -9); pinResidual(-9); pinSum(13);
      idle(6);

      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/fixed_encoder_var_order.md
Name: fixed_encoder_var_order

Overview:
Parametrised successor to the per-order fixed FLAC encoders. It computes fixed-predictor residuals of runtime-selectable order 0..4 on one sample stream, with a width-grown output so no order can overflow. It passes warmup samples verbatim, tracks frame boundaries, and accumulates the per-frame |residual| sum that the order-selection logic downstream uses. Sits between the sample buffer and the Rice parameter/order chooser.

Parameters:
SAMPLE_WIDTH, 16, signed input sample width
RES_WIDTH, SAMPLE_WIDTH+4, signed residual width; derived, not overridable; sum of coefficient magnitudes is 16, so +4 bits cannot overflow
SUM_WIDTH, 32, unsigned width of the per-frame |residual| accumulator; saturating

Ports:
iClock  in  1  clock
iReset_n  in  1  reset; asynchronous, active-low
iEnable  in  1  iSample valid this cycle; no backpressure
iFrameStart  in  1  qualifies iEnable: first sample of a frame; latches iOrder
iFrameLast  in  1  qualifies iEnable: last sample of a frame
iOrder  in  3  predictor order; 5..7 clamp to 4
iSample  in  SAMPLE_WIDTH  signed input sample
oValid  out  1  oResidual valid
oWarmup  out  1  oResidual is a verbatim warmup sample
oResidual  out  RES_WIDTH  signed residual, or sign-extended warmup sample
oOrder  out  3  clamped order in force for the frame currently at the output
oAbsSum  out  SUM_WIDTH  completed frame |residual| sum; held until the next frame completes
oSumValid  out  1  one-cycle pulse when oAbsSum updates

Behaviour:
- Reset (async assert, sync-safe deassert): all outputs 0; history x1..x4 = 0; sample counter = 0; frame order = 0; accumulator = 0; all pipeline valid/tag bits = 0.
- Pipeline: free-running, one valid/tag bit per stage; bubbles when iEnable=0. A sample accepted at edge N gives oValid=1 after edge N+3. Fixed latency of 3 for every order.
- Stage 0: register the sample and tags (start, last, warmup). Shift history x4<=x3 ... x1<=x0 only on valid samples. On iFrameStart, latch min(iOrder,4) as the frame order and restart the sample counter. The counter saturates at 4. Warmup = (counter < order). iOrder is ignored when iFrameStart=0.
- Stage 1: p = x0 + k2*x2 + k4*x4 and q = k1*x1 + k3*x3, all computed with shifts and adds, no multipliers. Coefficient magnitudes by order:
  - order 0: k = 0,0,0,0
  - order 1: k1 = 1
  - order 2: k1 = 2, k2 = 1
  - order 3: k1 = 3, k2 = 3, k3 = 1
  - order 4: k1 = 4, k2 = 6, k3 = 4, k4 = 1
  - Unused coefficients are 0.
- Stage 2: oResidual = p - q at RES_WIDTH. Warmup samples output x0 sign-extended with oWarmup=1.
- History is not cleared at frame start. Stale values are only reachable during warmup, where they are masked.
- Order takes effect on the frame's first sample and applies per-sample via the pipeline tag. A frame in flight never changes order.
- Accumulator, on each valid output:
  - start-tagged sample: load |res| (0 if warmup).
  - otherwise: add |res| (0 if warmup), saturating at 2^SUM_WIDTH-1.
  - last-tagged sample: one cycle later, oAbsSum <= final sum and oSumValid = 1 for exactly one cycle.
- Boundary cases:
  - iFrameStart and iFrameLast together: one-sample frame; sum = 0 if order >= 1, else |x0|.
  - iFrameStart with no preceding iFrameLast: the abandoned frame's sum is discarded; no oSumValid for it.
  - Back-to-back frames: last of frame A on one cycle, start of frame B on the next. Both are handled with no bubble, and A's oSumValid coincides with B's first output.
  - Samples before any iFrameStart after reset use order 0.
  - iReset_n asserted mid-frame: pipeline contents dropped, no oSumValid.
  - |most negative RES_WIDTH value| cannot occur (max magnitude 2^(SAMPLE_WIDTH+3)), so abs needs no special case.

Decomposition:
- Package flac_fixed_pkg holds MAX_FIXED_ORDER = 4, ORDER_W = 3, the per-order coefficient magnitude constants (k1..k4), and the clamp function.
- Sub-module fixed_abs_accumulator holds the tagged load/add, saturation, and the oSumValid/oAbsSum register.
- Predictor datapath stays in the top.

Test Plan:
- Order 0, samples 5,-3,7 (start on 5, last on 7) -> oResidual 5,-3,7, oWarmup 0, latency 3, oAbsSum 15 with oSumValid pulse.
- Ramp 0..9, order 3 -> first 3 outputs warmup 0,1,2, then residual 0 x7. Same ramp at order 1 -> residual 1 after 1 warmup. oAbsSum 0 for order 3, 9 for order 1.
- Order 4, SAMPLE_WIDTH 16, samples -32768,32767,-32768,32767,-32768 -> 5th output -524280; no wrap in the 20-bit residual.
- Order 1, frame 10,13,7,7 -> warmup 10, then 3,-6,0; oAbsSum 9, pulse one cycle after last output. Next frame immediately with iOrder 6 -> oOrder 4.
- Frame in progress with iEnable gaps; assert iReset_n low mid-frame -> all outputs 0 immediately. Then a new frame at order 2 on 1,4,9,16 -> residuals 2,2 after 2 warmup.
- One-sample frame (start+last) at order 2 -> oWarmup 1, oAbsSum 0, oSumValid pulse.
